// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war match controller.
// Holds the FSM state encoding and the seven-segment glyphs.
package tug_pkg;

  typedef enum logic [1:0] {
    RESTART    = 2'd0,
    PLAY       = 2'd1,
    MATCH_OVER = 2'd2
  } state_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/tug_scorekeeper_if.sv
// Playfield-side bundle of the scorekeeper: button pulses and end lights in,
// round reset, scores, digits and match status out.
interface tug_scorekeeper_if #(
  parameter int SCORE_W = 4
) ();

  logic               L;
  logic               R;
  logic               end_l;
  logic               end_r;
  logic               new_match;
  logic               round_rst;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic [6:0]         hex_l;
  logic [6:0]         hex_r;
  logic               match_over;
  logic               winner;

  modport master (
    output L, R, end_l, end_r, new_match,
    input  round_rst, score_l, score_r,
    input  hex_l, hex_r, match_over, winner
  );

  modport slave (
    input  L, R, end_l, end_r, new_match,
    output round_rst, score_l, score_r,
    output hex_l, hex_r, match_over, winner
  );

endinterface

// File: rtl/seg7_digit.sv
// Decimal digit to active-low seven-segment glyph.
// Values above 9 blank the digit.
module seg7_digit
  import tug_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (val_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tug_scorekeeper.sv
// Match controller for the tug-of-war playfield: detects round wins,
// keeps scores, holds the bar in reset between rounds, ends the match.
module tug_scorekeeper
  import tug_pkg::*;
#(
  parameter int WIN_SCORE      = 7,
  parameter int RESTART_CYCLES = 4,
  parameter int SCORE_W        = 4
) (
  input  logic               Clock,
  input  logic               Reset_n,
  tug_scorekeeper_if.slave   bus
);

  localparam int CNT_W = $clog2(RESTART_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(RESTART_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_S =
    SCORE_W'(WIN_SCORE);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SCORE_W-1:0] score_l_q;
  logic [SCORE_W-1:0] score_r_q;
  logic [SCORE_W-1:0] score_l_d;
  logic [SCORE_W-1:0] score_r_d;
  logic               round_rst_q;
  logic               over_q;
  logic               winner_q;
  logic               win_l;
  logic               win_r;

  // A simultaneous press cancels out; each side needs its own end light
  assign win_l = bus.L & ~bus.R & bus.end_l;
  assign win_r = bus.R & ~bus.L & bus.end_r;

  assign score_l_d = score_l_q + SCORE_W'(1);
  assign score_r_d = score_r_q + SCORE_W'(1);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= RESTART;
      cnt_q       <= CNT_INIT;
      score_l_q   <= '0;
      score_r_q   <= '0;
      round_rst_q <= 1'b1;
      over_q      <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      case (state_q)
        RESTART: begin
          if (cnt_q == '0) begin
            state_q     <= PLAY;
            round_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        PLAY: begin
          if (win_l) begin
            score_l_q   <= score_l_d;
            round_rst_q <= 1'b1;
            if (score_l_d == WIN_S) begin
              state_q  <= MATCH_OVER;
              over_q   <= 1'b1;
              winner_q <= 1'b0;
            end else begin
              state_q <= RESTART;
              cnt_q   <= CNT_INIT;
            end
          end else if (win_r) begin
            score_r_q   <= score_r_d;
            round_rst_q <= 1'b1;
            if (score_r_d == WIN_S) begin
              state_q  <= MATCH_OVER;
              over_q   <= 1'b1;
              winner_q <= 1'b1;
            end else begin
              state_q <= RESTART;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        MATCH_OVER: begin
          if (bus.new_match) begin
            state_q     <= RESTART;
            cnt_q       <= CNT_INIT;
            score_l_q   <= '0;
            score_r_q   <= '0;
            over_q      <= 1'b0;
            winner_q    <= 1'b0;
            round_rst_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= RESTART;
          cnt_q       <= CNT_INIT;
          round_rst_q <= 1'b1;
        end
      endcase
    end
  end

  seg7_digit u_hex_l (
    .val_i (4'(score_l_q)),
    .seg_o (bus.hex_l)
  );

  seg7_digit u_hex_r (
    .val_i (4'(score_r_q)),
    .seg_o (bus.hex_r)
  );

  assign bus.round_rst  = round_rst_q;
  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.match_over = over_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_tug_scorekeeper.sv
// Bench for tug_scorekeeper: match-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_tug_scorekeeper;

  localparam int WIN = 3;
  localparam int RC  = 4;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;

  tug_scorekeeper_if #(.SCORE_W(4)) bus ();

  tug_scorekeeper #(
    .WIN_SCORE      (WIN),
    .RESTART_CYCLES (RC),
    .SCORE_W        (4)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Glyph table written out independently of the design package
  logic [6:0] glyph [0:15];
  initial begin
    glyph[0] = 7'b1000000; glyph[1] = 7'b1111001;
    glyph[2] = 7'b0100100; glyph[3] = 7'b0110000;
    glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
    glyph[6] = 7'b0000010; glyph[7] = 7'b1111000;
    glyph[8] = 7'b0000000; glyph[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) glyph[i] = 7'b1111111;
  end

  // Match model: rounds of reset hold remaining, scores, match flag
  int m_hold, m_sl, m_sr;
  bit m_over, m_win;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m_hold = RC; m_sl = 0; m_sr = 0;
      m_over = 0;  m_win = 0;
    end else if (m_over) begin
      if (bus.new_match) begin
        m_sl = 0; m_sr = 0; m_win = 0;
        m_over = 0; m_hold = RC;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (bus.L && !bus.R && bus.end_l) begin
      m_sl++;
      if (m_sl == WIN) begin m_over = 1; m_win = 0; end
      else m_hold = RC;
    end else if (bus.R && !bus.L && bus.end_r) begin
      m_sr++;
      if (m_sr == WIN) begin m_over = 1; m_win = 1; end
      else m_hold = RC;
    end
  end

  always @(negedge Clock) begin
    if (Reset_n) begin
      chk("m_round_rst", int'(bus.round_rst),
          int'(m_over || m_hold > 0));
      chk("m_score_l", int'(bus.score_l), m_sl);
      chk("m_score_r", int'(bus.score_r), m_sr);
      chk("m_hex_l", int'(bus.hex_l), int'(glyph[m_sl]));
      chk("m_hex_r", int'(bus.hex_r), int'(glyph[m_sr]));
      chk("m_match_over", int'(bus.match_over), int'(m_over));
      chk("m_winner", int'(bus.winner), int'(m_win));
    end
  end

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_round_rst", int'(bus.round_rst), 1);
    chk("rst_score_l", int'(bus.score_l), 0);
    chk("rst_score_r", int'(bus.score_r), 0);
    chk("rst_hex_l", int'(bus.hex_l), 7'b1000000);
    chk("rst_hex_r", int'(bus.hex_r), 7'b1000000);
    chk("rst_match_over", int'(bus.match_over), 0);
    chk("rst_winner", int'(bus.winner), 0);
  endtask

  task automatic count_rst(int exp);
    int n = 0;
    while (bus.round_rst && n < 20) begin
      n++;
      tick();
    end
    chk("round_rst_len", n, exp);
  endtask

  task automatic wait_play();
    int n = 0;
    while (bus.round_rst && n < 30) begin
      tick();
      n++;
    end
    if (bus.round_rst) chk("wait_play_timeout", 1, 0);
  endtask

  task automatic win_left();
    wait_play();
    bus.end_l = 1'b1; bus.L = 1'b1;
    tick();
    bus.end_l = 1'b0; bus.L = 1'b0;
  endtask

  task automatic win_right();
    wait_play();
    bus.end_r = 1'b1; bus.R = 1'b1;
    tick();
    bus.end_r = 1'b0; bus.R = 1'b0;
  endtask

  initial begin
    bus.L = 1'b0; bus.R = 1'b0;
    bus.end_l = 1'b0; bus.end_r = 1'b0;
    bus.new_match = 1'b0;
    tick();
    chk_reset_vals();
    tick();
    Reset_n = 1'b1;

    // 1: initial restart hold then play
    count_rst(4);
    chk("play_score_l", int'(bus.score_l), 0);
    chk("play_hex_r", int'(bus.hex_r), 7'b1000000);

    // 2: left round win
    bus.end_l = 1'b1; bus.L = 1'b1;
    tick();
    bus.L = 1'b0;
    chk("lwin_score_l", int'(bus.score_l), 1);
    chk("lwin_hex_l", int'(bus.hex_l), 7'b1111001);
    count_rst(4);

    // 3: simultaneous press cancels
    bus.L = 1'b1; bus.R = 1'b1;
    tick();
    bus.L = 1'b0; bus.R = 1'b0; bus.end_l = 1'b0;
    chk("tie_score_l", int'(bus.score_l), 1);
    chk("tie_score_r", int'(bus.score_r), 0);
    chk("tie_round_rst", int'(bus.round_rst), 0);

    // 4: right press without end light; stray new_match
    bus.R = 1'b1; bus.new_match = 1'b1;
    tick();
    bus.R = 1'b0; bus.new_match = 1'b0;
    chk("noend_score_r", int'(bus.score_r), 0);
    chk("noend_round_rst", int'(bus.round_rst), 0);
    bus.end_r = 1'b1; bus.R = 1'b1;
    tick();
    chk("rwin_score_r", int'(bus.score_r), 1);
    tick();
    bus.R = 1'b0; bus.end_r = 1'b0;
    chk("restart_ign_r", int'(bus.score_r), 1);

    // 5: right takes the match
    win_right();
    win_right();
    chk("mo_score_r", int'(bus.score_r), 3);
    chk("mo_hex_r", int'(bus.hex_r), 7'b0110000);
    chk("mo_match_over", int'(bus.match_over), 1);
    chk("mo_winner", int'(bus.winner), 1);
    chk("mo_round_rst", int'(bus.round_rst), 1);
    bus.end_l = 1'b1; bus.end_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.L = i[0]; bus.R = ~i[0];
      tick();
    end
    bus.L = 1'b0; bus.R = 1'b0;
    bus.end_l = 1'b0; bus.end_r = 1'b0;
    chk("frozen_score_l", int'(bus.score_l), 1);
    chk("frozen_score_r", int'(bus.score_r), 3);
    bus.new_match = 1'b1;
    tick();
    bus.new_match = 1'b0;
    chk("nm_score_r", int'(bus.score_r), 0);
    chk("nm_match_over", int'(bus.match_over), 0);
    count_rst(4);

    // left sweeps the next match
    for (int i = 0; i < 3; i++) win_left();
    chk("lmo_score_l", int'(bus.score_l), 3);
    chk("lmo_hex_l", int'(bus.hex_l), 7'b0110000);
    chk("lmo_match_over", int'(bus.match_over), 1);
    chk("lmo_winner", int'(bus.winner), 0);

    // 6: async reset mid-MATCH_OVER and mid-RESTART
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    chk_reset_vals();
    tick();
    Reset_n = 1'b1;
    count_rst(4);
    win_left();
    chk("pre_rst_score_l", int'(bus.score_l), 1);
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    chk_reset_vals();
    tick();
    Reset_n = 1'b1;
    count_rst(4);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
